// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag
//   Captures an 8x8 block of signed fixed-point DCT coefficients, then streams
//   64 quantized coefficients one per accepted beat. Each coefficient is
//   multiplied by a reciprocal quantizer (Q1.15) from a writable 64-entry
//   table, rounded half away from zero and saturated to OUT_W bits.
//
//   Build option: define DCTQ_ZIGZAG_EN to emit beats in JPEG zigzag order;
//   otherwise beats are emitted in raster order. Timing is identical.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        block handshake, in_data = 64 x IN_W row-major
//     qtab_we/addr/data        reciprocal table write port (row-major index)
//     out_valid/out_ready      beat handshake
//     out_data                 quantized coefficient
//     out_idx                  scan position 0..63
//     out_last                 high on the beat with out_idx == 63
module dct_quant_zigzag #(
  parameter int IN_W  = 32,
  parameter int FRAC  = 8,
  parameter int OUT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [64*IN_W-1:0]       in_data,
  input  logic                     qtab_we,
  input  logic [5:0]               qtab_addr,
  input  logic [15:0]              qtab_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [5:0]               out_idx,
  output logic                     out_last
);

  localparam int PW = IN_W + 17;
  localparam int S  = FRAC + 15;

  localparam logic [PW-1:0] RND     = PW'(1) << (S - 1);
  localparam logic [PW-1:0] POS_MAX = (PW'(1) << (OUT_W - 1)) - PW'(1);
  localparam logic [PW-1:0] NEG_MAG = PW'(1) << (OUT_W - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

`ifdef DCTQ_ZIGZAG_EN
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
`endif

  logic [0:0]               state;
  logic [5:0]               k;
  logic signed [IN_W-1:0]   cbuf [64];
  logic [15:0]              qtab [64];

  logic [5:0]               next_k;
  logic [5:0]               src;
  logic signed [IN_W-1:0]   coeff;
  logic [15:0]              recip;
  logic signed [PW-1:0]     prod;
  logic [PW-1:0]            mag;
  logic [PW-1:0]            rnd_mag;
  logic signed [OUT_W-1:0]  q;

  assign in_ready = !rst && (state == IDLE) && !out_valid;
  assign out_idx  = k;

  // Coefficient buffer: no reset, only loaded on block acceptance.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int unsigned i = 0; i < 64; i++) begin
        cbuf[i] <= in_data[i*IN_W +: IN_W];
      end
    end
  end

  // Reading is combinational from the registered table, so a write landing on
  // the same edge that loads a beat leaves that beat with the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 64; i++) begin
        qtab[i] <= 16'h8000;
      end
    end else if (qtab_we) begin
      qtab[qtab_addr] <= qtab_data;
    end
  end

  // Beat to be loaded at the next edge: the first beat reuses k (=0), later
  // beats are loaded as the current one is accepted.
  always_comb begin
    next_k = out_valid ? k + 6'd1 : k;
`ifdef DCTQ_ZIGZAG_EN
    src    = ZZ[next_k];
`else
    src    = next_k;
`endif
    coeff  = cbuf[src];
    recip  = qtab[src];
    prod   = PW'(coeff) * PW'($signed({1'b0, recip}));
    mag    = prod[PW-1] ? $unsigned(-prod) : $unsigned(prod);
    rnd_mag = (mag + RND) >> S;
    if (prod[PW-1]) begin
      if (rnd_mag > NEG_MAG) q = {1'b1, {(OUT_W-1){1'b0}}};
      else                   q = -$signed(rnd_mag[OUT_W-1:0]);
    end else begin
      if (rnd_mag > POS_MAX) q = {1'b0, {(OUT_W-1){1'b1}}};
      else                   q = $signed(rnd_mag[OUT_W-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state <= SCAN;
            k     <= '0;
          end
        end
        SCAN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= q;
            out_last  <= (next_k == 6'd63);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
              k         <= '0;
            end else begin
              k        <= next_k;
              out_data <= q;
              out_last <= (next_k == 6'd63);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
module tb_dct_quant_zigzag;

  localparam int IN_W  = 32;
  localparam int FRAC  = 8;
  localparam int OUT_W = 16;
  localparam int S     = FRAC + 15;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [64*IN_W-1:0]      in_data = '0;
  logic                    qtab_we = 1'b0;
  logic [5:0]              qtab_addr = '0;
  logic [15:0]             qtab_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic [5:0]              out_idx;
  logic                    out_last;

  dct_quant_zigzag #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .qtab_we(qtab_we), .qtab_addr(qtab_addr), .qtab_data(qtab_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int coeff;
    int recip;
    int expq;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int order [64];
  int qt    [64];
  int blk   [64];
  int expd  [64];
  int rx_data [64];
  int rx_idx  [64];
  int rx_last [64];
  int first_valid_cyc;
  int total_cyc;
  bit ir_bad;
  bit stab_bad;

  localparam int WR_A = 16'h1234;
  localparam int WR_B = 16'h0400;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference quantizer: sign(P) * ((|P| + 2^(S-1)) >> S), saturated.
  function automatic int qref(input int c, input int r);
    longint p, m, q;
    p = longint'(c) * longint'(r);
    m = (p < 0) ? -p : p;
    q = (m + (longint'(1) << (S - 1))) >>> S;
    if (p < 0) q = -q;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Scan order from first principles: walk anti-diagonals, alternating direction.
  function automatic void gen_order();
`ifdef DCTQ_ZIGZAG_EN
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int t = 0; t < 8; t++) begin
        int r;
        int c;
        r = (s % 2 == 1) ? t : 7 - t;
        c = s - r;
        if (c >= 0 && c < 8) begin
          order[n] = r * 8 + c;
          n++;
        end
      end
    end
`else
    for (int i = 0; i < 64; i++) order[i] = i;
`endif
  endfunction

  function automatic void compute_exp();
    for (int i = 0; i < 64; i++) expd[i] = qref(blk[order[i]], qt[order[i]]);
  endfunction

  function automatic int rcoef();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 2097152)) - 1048576;
      2:       return 0;
      default: return int'($urandom_range(0, 16384)) - 8192;
    endcase
  endfunction

  task automatic write_q(input int a, input int d);
    @(negedge clk);
    qtab_we   = 1'b1;
    qtab_addr = 6'(a);
    qtab_data = 16'(d);
    @(negedge clk);
    qtab_we = 1'b0;
    qt[a] = d;
  endtask

  task automatic send_block();
    logic [64*IN_W-1:0] v;
    int w;
    for (int i = 0; i < 64; i++) v[i*IN_W +: IN_W] = blk[i];
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: alternate 1/0, 2: random
  task automatic collect(input int mode, input bit writes, input bit hold);
    int beats;
    int cyc;
    bit prev_stall;
    bit rdy;
    logic signed [OUT_W-1:0] pd;
    logic [5:0] pi;
    logic pl;
    beats = 0; cyc = 0; prev_stall = 0;
    pd = '0; pi = '0; pl = 1'b0;
    first_valid_cyc = 0; ir_bad = 0; stab_bad = 0;
    if (hold) begin
      in_valid = 1'b1;
      in_data  = {64{$urandom}};
    end else begin
      in_valid = 1'b0;
    end
    while (beats < 64 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      qtab_we = 1'b0;
      if (in_ready) ir_bad = 1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      if (out_valid) begin
        if (first_valid_cyc == 0) first_valid_cyc = cyc;
        if (prev_stall && (out_data !== pd || out_idx !== pi || out_last !== pl)) stab_bad = 1;
        if (writes && !prev_stall && out_idx == 6'd10) begin
          rdy = 1'b0;
          qtab_we = 1'b1; qtab_addr = 6'(order[11]); qtab_data = 16'(WR_A);
        end
        if (writes && !prev_stall && out_idx == 6'd20) begin
          rdy = 1'b1;
          qtab_we = 1'b1; qtab_addr = 6'(order[21]); qtab_data = 16'(WR_B);
        end
        out_ready = rdy;
        if (rdy) begin
          rx_data[beats] = int'(out_data);
          rx_idx[beats]  = int'(out_idx);
          rx_last[beats] = int'(out_last);
          beats++;
        end
        prev_stall = !rdy;
        pd = out_data; pi = out_idx; pl = out_last;
      end else begin
        out_ready = rdy;
        prev_stall = 0;
      end
    end
    total_cyc = cyc;
    in_valid = 1'b0;
    if (beats < 64) chk("beat_timeout", beats, 64);
  endtask

  task automatic run_block(input int mode, input bit writes, input bit hold);
    send_block();
    collect(mode, writes, hold);
    @(negedge clk);
    qtab_we = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("first_beat_latency", first_valid_cyc, 2);
    chk("in_ready_low_scan", ir_bad, 0);
    chk("stall_stable", stab_bad, 0);
    if (mode == 0) chk("no_bubble_cycles", total_cyc, 65);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("idx[%0d]", i), rx_idx[i], i);
      chk($sformatf("last[%0d]", i), rx_last[i], (i == 63) ? 1 : 0);
      chk($sformatf("data[%0d]", i), rx_data[i], expd[i]);
    end
  endtask

  initial begin
    vec_t vt [11];
    int zz10 [10];
    int nz;
    int w;

    vt[0]  = '{6144,      16'h0800, 2};
    vt[1]  = '{-6144,     16'h0800, -2};
    vt[2]  = '{5888,      16'h0800, 1};
    vt[3]  = '{10240000,  16'h8000, 32767};
    vt[4]  = '{-10240000, 16'h8000, -32768};
    vt[5]  = '{128,       16'h8000, 1};
    vt[6]  = '{-128,      16'h8000, -1};
    vt[7]  = '{127,       16'h8000, 0};
    vt[8]  = '{-384,      16'h8000, -2};
    vt[9]  = '{8388608,   16'h8000, 32767};
    vt[10] = '{-8388608,  16'h8000, -32768};
    zz10 = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};

    gen_order();
    for (int i = 0; i < 64; i++) qt[i] = 16'h8000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // DC-only block through the reset table
    for (int i = 0; i < 64; i++) blk[i] = 0;
    blk[0] = 25600;
    compute_exp();
    run_block(0, 0, 0);
    chk("dc_value", rx_data[0], 100);
    nz = 0;
    for (int i = 1; i < 64; i++) if (rx_data[i] != 0) nz++;
    chk("dc_rest_zero", nz, 0);

    // Ramp block exposes scan order
    for (int i = 0; i < 64; i++) blk[i] = i << 8;
    compute_exp();
    run_block(0, 0, 0);
`ifdef DCTQ_ZIGZAG_EN
    for (int i = 0; i < 10; i++) chk($sformatf("zz_lit[%0d]", i), rx_data[i], zz10[i]);
`else
    for (int i = 0; i < 10; i++) chk($sformatf("raster_lit[%0d]", i), rx_data[i], i);
`endif
    chk("scan_last", rx_data[63], 63);

    // Rounding and saturation vectors on element 0 (first beat in any order)
    foreach (vt[j]) begin
      write_q(0, vt[j].recip);
      for (int i = 0; i < 64; i++) blk[i] = 0;
      blk[0] = vt[j].coeff;
      compute_exp();
      run_block(0, 0, 0);
      chk($sformatf("vec%0d", j), rx_data[0], vt[j].expq);
    end
    write_q(0, 16'h8000);

    // Alternating stall, in_valid held high during SCAN
    for (int i = 0; i < 64; i++) blk[i] = rcoef();
    compute_exp();
    run_block(1, 0, 1);

    // Table writes mid-scan: held beat unaffected, later beat uses new value,
    // same-cycle write leaves the beat being loaded with the old value.
    for (int i = 0; i < 8; i++) write_q($urandom_range(0, 63), $urandom_range(1, 65535));
    write_q(order[21], 16'h6000);
    for (int i = 0; i < 64; i++) blk[i] = rcoef();
    blk[order[11]] = 256000;
    blk[order[21]] = -256000;
    qt[order[11]] = WR_A;
    compute_exp();
    run_block(2, 1, 0);
    qt[order[21]] = WR_B;

    // Random blocks with random tables and back-pressure
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) write_q($urandom_range(0, 63), $urandom_range(0, 65535));
      for (int i = 0; i < 64; i++) blk[i] = rcoef();
      compute_exp();
      run_block(b % 3, 0, 0);
    end

    // Reset in the middle of a scan
    for (int i = 0; i < 6; i++) write_q(order[i], $urandom_range(1, 16'h7fff));
    for (int i = 0; i < 64; i++) blk[i] = rcoef();
    send_block();
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (!(out_valid && out_idx == 6'd20) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("beat20_reached", out_idx, 20);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_idx", out_idx, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", in_ready, 1);
    for (int i = 0; i < 64; i++) qt[i] = 16'h8000;
    for (int i = 0; i < 64; i++) blk[i] = i << 8;
    compute_exp();
    run_block(0, 0, 0);
    for (int i = 0; i < 64; i++) blk[i] = rcoef();
    compute_exp();
    run_block(2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
